// File: rtl/acc_host_link.sv
// Host-side link for the neural accelerator: packs host bytes into 4-byte vectors,
// issues them under a result-credit rule, and buffers results in a show-ahead FIFO.
module acc_host_link #(
    parameter int unsigned RES_DEPTH = 4,
    parameter int unsigned CW        = 3
) (
    input  logic          clk,
    input  logic          arst,
    input  logic [7:0]    in_byte,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_byte,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    acc_x1,
    output logic [7:0]    acc_x2,
    output logic [7:0]    acc_x3,
    output logic [7:0]    acc_x4,
    output logic          acc_valid,
    input  logic          acc_ready,
    input  logic [7:0]    acc_y,
    input  logic          acc_valid_out,
    output logic          acc_ready_out,
    output logic [CW-1:0] inflight,
    output logic          err_unexp
);

    localparam int unsigned AW = $clog2(RES_DEPTH);

    typedef enum logic {StFill, StSend} state_e;

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    x_q [4];
    logic [7:0]    x_d [4];
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic          err_q, err_d;
    logic [7:0]    mem_q [RES_DEPTH];

    logic          fifo_full, fifo_empty, credit_ok;
    logic          issue, push, pop, unexp;
    logic [CW:0]   used;

    // Slots already promised: results still in flight plus results sitting in the FIFO.
    assign used       = {1'b0, inflight_q} + {1'b0, count_q};
    assign credit_ok  = used < (CW+1)'(RES_DEPTH);
    assign fifo_full  = count_q == CW'(RES_DEPTH);
    assign fifo_empty = count_q == '0;

    assign in_ready      = state_q == StFill;
    assign acc_valid     = (state_q == StSend) && credit_ok;
    assign acc_ready_out = !fifo_full;
    assign out_valid     = !fifo_empty;
    assign out_byte      = fifo_empty ? 8'h00 : mem_q[rd_q];

    assign issue = acc_valid && acc_ready;
    assign push  = acc_valid_out && acc_ready_out;
    assign pop   = out_valid && out_ready;
    assign unexp = push && (inflight_q == '0);

    assign acc_x1    = x_q[0];
    assign acc_x2    = x_q[1];
    assign acc_x3    = x_q[2];
    assign acc_x4    = x_q[3];
    assign inflight  = inflight_q;
    assign err_unexp = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        unique case (state_q)
            StFill: begin
                if (in_valid) begin
                    x_d[idx_q] = in_byte;
                    idx_d      = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = StSend;
                end
            end
            StSend: begin
                if (issue) state_d = StFill;
            end
        endcase
    end

    always_comb begin
        // An unexpected result does not decrement, so inflight saturates at zero.
        inflight_d = inflight_q + CW'(issue) - CW'(push && !unexp);
        err_d      = err_q || unexp;
        count_d    = count_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        if (push) wr_d = wr_q + AW'(1);
        if (pop)  rd_d = rd_q + AW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= StFill;
            idx_q      <= 2'd0;
            x_q        <= '{default: 8'h00};
            inflight_q <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: out_byte is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= acc_y;
    end

endmodule

// File: tb/tb_acc_host_link.sv
// Scoreboard bench for acc_host_link: expected vectors/results are queued by the stimulus
// and popped by a negedge monitor whenever a handshake is about to complete.
module tb_acc_host_link;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] acc_x1, acc_x2, acc_x3, acc_x4;
    logic       acc_valid;
    logic       acc_ready = 1'b0;
    logic [7:0] acc_y = 8'h00;
    logic       acc_valid_out = 1'b0;
    logic       acc_ready_out;
    logic [2:0] inflight;
    logic       err_unexp;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic auto_en = 1'b0;

    logic [31:0] exp_vec[$];
    logic [7:0]  exp_res[$];
    logic [7:0]  pend_y[$];
    int          pend_due[$];

    acc_host_link #(.RES_DEPTH(4), .CW(3)) dut (
        .clk(clk), .arst(arst),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .acc_x1(acc_x1), .acc_x2(acc_x2), .acc_x3(acc_x3), .acc_x4(acc_x4),
        .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_y(acc_y), .acc_valid_out(acc_valid_out), .acc_ready_out(acc_ready_out),
        .inflight(inflight), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: handshakes seen at negedge complete on the following posedge.
    always @(negedge clk) begin
        if (arst) begin
            if (acc_valid && acc_ready) begin
                if (exp_vec.size() == 0) chk("vec_unexpected", 32'd1, 32'd0);
                else chk("vec", {acc_x1, acc_x2, acc_x3, acc_x4}, exp_vec.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_res.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
                else chk("res", {24'd0, out_byte}, {24'd0, exp_res.pop_front()});
            end
        end
    end

    // Accelerator model outputs from the pending-result queue.
    task automatic refresh();
        if (pend_y.size() > 0 && pend_due[0] <= cyc) begin
            acc_valid_out = 1'b1;
            acc_y         = pend_y[0];
        end else begin
            acc_valid_out = 1'b0;
            acc_y         = 8'h00;
        end
    endtask

    // One clock; the model returns sum(X) two edges after an issue when auto_en is set.
    task automatic step();
        logic       fi, fr;
        logic [7:0] y;
        fi = acc_valid && acc_ready;
        fr = acc_valid_out && acc_ready_out;
        y  = acc_x1 + acc_x2 + acc_x3 + acc_x4;
        @(posedge clk);
        #1;
        cyc++;
        if (fr && pend_y.size() > 0) begin
            void'(pend_y.pop_front());
            void'(pend_due.pop_front());
        end
        if (fi && auto_en) begin
            pend_y.push_back(y);
            pend_due.push_back(cyc + 1);
        end
        refresh();
    endtask

    task automatic inject(input logic [7:0] y);
        pend_y.push_back(y);
        pend_due.push_back(cyc);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        exp_vec.push_back({a, b, c, d});
        send_byte(a);
        send_byte(b);
        send_byte(c);
        send_byte(d);
    endtask

    task automatic wait_fill();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_res.size() > 0 || pend_y.size() > 0) && n < 60) begin
            step();
            n++;
        end
        if (exp_res.size() > 0 || pend_y.size() > 0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
        chk("rst_ready_out", {31'd0, acc_ready_out}, 32'd1);
        chk("rst_x", {acc_x1, acc_x2, acc_x3, acc_x4}, 32'd0);
        chk("rst_inflight", {29'd0, inflight}, 32'd0);
        chk("rst_err", {31'd0, err_unexp}, 32'd0);
        @(posedge clk);
        #1;
        arst = 1'b1;

        // Single vector with accelerator ready: one-cycle acc_valid
        auto_en   = 1'b1;
        acc_ready = 1'b1;
        out_ready = 1'b1;
        exp_res.push_back(8'hEC);
        send_vec(8'd10, 8'hEC, 8'd30, 8'hD8);
        chk("t1_acc_valid", {31'd0, acc_valid}, 32'd1);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_inflight0", {29'd0, inflight}, 32'd0);
        step();
        chk("t1_acc_valid_drop", {31'd0, acc_valid}, 32'd0);
        chk("t1_inflight1", {29'd0, inflight}, 32'd1);
        drain();
        chk("t1_inflight_end", {29'd0, inflight}, 32'd0);

        // Stall in SEND with acc_ready low
        acc_ready = 1'b0;
        exp_res.push_back(8'd20);
        send_vec(8'd2, 8'd4, 8'd6, 8'd8);
        for (int i = 0; i < 6; i++) begin
            chk("t2_hold_valid", {31'd0, acc_valid}, 32'd1);
            chk("t2_hold_x", {acc_x1, acc_x2, acc_x3, acc_x4}, 32'h02040608);
            chk("t2_hold_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        acc_ready = 1'b1;
        step();
        chk("t2_single_xfer", {31'd0, acc_valid}, 32'd0);
        chk("t2_inflight", {29'd0, inflight}, 32'd1);
        drain();

        // Credit limit: FIFO full blocks the 5th vector
        out_ready = 1'b0;
        send_vec(8'd1, 8'd2, 8'd3, 8'd4);
        send_vec(8'd5, 8'd5, 8'd5, 8'd5);
        send_vec(8'd10, 8'd20, 8'd30, 8'd40);
        send_vec(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        send_vec(8'd100, 8'd100, 8'd50, 8'd0);
        for (int i = 0; i < 4; i++) step();
        chk("t3_blocked", {31'd0, acc_valid}, 32'd0);
        chk("t3_full", {31'd0, acc_ready_out}, 32'd0);
        chk("t3_head", {24'd0, out_byte}, 32'd10);
        chk("t3_inflight", {29'd0, inflight}, 32'd0);
        exp_res.push_back(8'd10);
        exp_res.push_back(8'd20);
        exp_res.push_back(8'd100);
        exp_res.push_back(8'hFC);
        exp_res.push_back(8'hFA);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t3_unblocked", {31'd0, acc_valid}, 32'd1);
        step();
        chk("t3_inflight_after", {29'd0, inflight}, 32'd1);
        drain();

        // Ordered results returned against three outstanding vectors
        auto_en = 1'b0;
        send_vec(8'd0, 8'd0, 8'd0, 8'd1);
        wait_fill();
        send_vec(8'd0, 8'd0, 8'd0, 8'd2);
        wait_fill();
        send_vec(8'd0, 8'd0, 8'd0, 8'd3);
        wait_fill();
        chk("t4_inflight3", {29'd0, inflight}, 32'd3);
        exp_res.push_back(8'd7);
        exp_res.push_back(8'hFD);
        exp_res.push_back(8'd100);
        inject(8'd7);
        inject(8'hFD);
        inject(8'd100);
        refresh();
        chk("t4_out_valid_before", {31'd0, out_valid}, 32'd0);
        step();
        chk("t4_out_valid_after", {31'd0, out_valid}, 32'd1);
        chk("t4_first_byte", {24'd0, out_byte}, 32'd7);
        drain();
        chk("t4_inflight_end", {29'd0, inflight}, 32'd0);
        chk("t4_no_err", {31'd0, err_unexp}, 32'd0);

        // Unexpected result with nothing in flight
        out_ready = 1'b0;
        inject(8'd55);
        refresh();
        step();
        chk("t5_err", {31'd0, err_unexp}, 32'd1);
        chk("t5_inflight", {29'd0, inflight}, 32'd0);
        chk("t5_buffered", {24'd0, out_byte}, 32'd55);
        exp_res.push_back(8'd55);
        drain();
        chk("t5_err_sticky", {31'd0, err_unexp}, 32'd1);

        // Asynchronous reset mid-vector with buffered results
        out_ready = 1'b0;
        auto_en   = 1'b1;
        inject(8'h21);
        inject(8'h22);
        refresh();
        step();
        step();
        send_byte(8'h55);
        send_byte(8'h66);
        chk("t6_pre_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_pre_x1", {24'd0, acc_x1}, 32'h55);
        arst = 1'b0;
        #1;
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_out_byte", {24'd0, out_byte}, 32'd0);
        chk("t6_x", {acc_x1, acc_x2, acc_x3, acc_x4}, 32'd0);
        chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t6_inflight", {29'd0, inflight}, 32'd0);
        chk("t6_err", {31'd0, err_unexp}, 32'd0);
        chk("t6_ready_out", {31'd0, acc_ready_out}, 32'd1);
        pend_y.delete();
        pend_due.delete();
        exp_res.delete();
        refresh();
        step();
        arst = 1'b1;
        exp_res.push_back(8'd110);
        out_ready = 1'b1;
        send_vec(8'd11, 8'd22, 8'd33, 8'd44);
        wait_fill();
        drain();
        chk("vec_left", exp_vec.size(), 32'd0);
        chk("final_inflight", {29'd0, inflight}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
